// File: rtl/alu_lockstep_ctrl.sv
// -----------------------------------------------------------------------------
// alu_lockstep_ctrl
//
// Sequencing and response end of the dual-lane lockstep ALU. One operation is
// accepted per request handshake, executed on two identical ALU lanes, and the
// lane outputs ({carry,result}) are compared. A mismatch re-executes the
// operation up to MAX_RETRY times; if the final attempt still mismatches the
// response carries rsp_fault=1. Lane 2 can be corrupted with an XOR mask to
// exercise the checker.
//
// Handshake semantics (both request and response sides): a transfer happens
// on a rising clock edge where valid && ready are both 1. The producer holds
// valid and its payload stable until that edge; ready never depends on valid
// in the same cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake, ready only while idle
//   req_a, req_b, req_sel operands and op select (00 add, 01 sub, 10 and, 11 or)
//   inj_en, inj_perm,     lane-2 fault injection controls, sampled at accept
//   inj_mask
//   rsp_valid/rsp_ready   response handshake
//   rsp_result, rsp_carry lane-1 result and carry
//   rsp_fault             final attempt mismatched
//   fault_sticky          set by any faulted response, cleared by clr_fault
//   fault_count           saturating count of mismatching comparisons
//   clr_fault             synchronous clear of fault_sticky and fault_count
// -----------------------------------------------------------------------------
module alu_lockstep_ctrl #(
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 2,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_sel,
   input  logic             inj_en,
   input  logic             inj_perm,
   input  logic [WIDTH:0]   inj_mask,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_fault,
   output logic             fault_sticky,
   output logic [CNT_W-1:0] fault_count,
   input  logic             clr_fault
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CMP  = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

   // state is kept as a named enum so checkers can bind to it directly
   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       sel_q;
   logic             inj_en_q;
   logic             inj_perm_q;
   logic [WIDTH:0]   inj_mask_q;
   logic [2:0]       retry;
   logic [WIDTH:0]   lane1;
   logic [WIDTH:0]   lane2;

   logic [WIDTH:0]   lane1_d;
   logic [WIDTH:0]   lane2_d;
   logic             inj_active;
   logic             mismatch;
   logic             cnt_sat;

   // Lane function: {carry,result}; for sub, bit WIDTH is the borrow
   function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [1:0]       sel);
      logic [WIDTH:0] r;
      case (sel)
         2'b00:   r = {1'b0, a} + {1'b0, b};
         2'b01:   r = {1'b0, a} - {1'b0, b};
         2'b10:   r = {1'b0, a & b};
         default: r = {1'b0, a | b};
      endcase
      return r;
   endfunction

   always_comb begin
      inj_active = inj_en_q && (inj_perm_q || (retry == 3'd0));
      lane1_d    = alu_f(a_q, b_q, sel_q);
      lane2_d    = alu_f(a_q, b_q, sel_q) ^ (inj_active ? inj_mask_q : '0);
      mismatch   = |(lane1 ^ lane2);
      cnt_sat    = &fault_count;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_fault    <= 1'b0;
         fault_sticky <= 1'b0;
         fault_count  <= '0;
         retry        <= 3'd0;
         a_q          <= '0;
         b_q          <= '0;
         sel_q        <= 2'b00;
         inj_en_q     <= 1'b0;
         inj_perm_q   <= 1'b0;
         inj_mask_q   <= '0;
         lane1        <= '0;
         lane2        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_q        <= req_a;
                  b_q        <= req_b;
                  sel_q      <= req_sel;
                  inj_en_q   <= inj_en;
                  inj_perm_q <= inj_perm;
                  inj_mask_q <= inj_mask;
                  retry      <= 3'd0;
                  req_ready  <= 1'b0;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               lane1 <= lane1_d;
               lane2 <= lane2_d;
               state <= CMP;
            end
            CMP: begin
               if (mismatch && (retry < MAX_R)) begin
                  retry <= retry + 3'd1;
                  state <= EXEC;
               end else begin
                  // Response always reports lane 1; fault only if still mismatched
                  rsp_result <= lane1[WIDTH-1:0];
                  rsp_carry  <= lane1[WIDTH];
                  rsp_fault  <= mismatch;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Software clear wins over a same-cycle increment or sticky set
         if (clr_fault) begin
            fault_count  <= '0;
            fault_sticky <= 1'b0;
         end else if (state == CMP && mismatch) begin
            if (!cnt_sat) fault_count <= fault_count + 1'b1;
            if (retry >= MAX_R) fault_sticky <= 1'b1;
         end
      end
   end

endmodule
